// File: rtl/sn74ls194_seq_pkg.sv
// Shared encodings for the 194-type shift-register sequencer: FSM states and register mode pins.
package sn74ls194_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // dir=0 shifts toward the MSB (serial in on r), dir=1 toward the LSB (serial in on l).
  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/sn74ls194_seq_cnt.sv
// Loadable down-counter for the sequencer: saturating load, decrement, zero and one flags.
module sn74ls194_seq_cnt #(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned MAX_SHIFT = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_zero_o,
  output logic             is_one_o
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_SHIFT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      // Oversized requests clamp to the largest legal count instead of wrapping.
      cnt_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_o = (cnt_q == '0);
  assign is_one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sn74ls194_seq.sv
// Load-then-shift-N sequencer driving 194-type shift-register mode, load and serial pins.
// Define SN74LS194_SEQ_ROTATE_EN to feed the serial input from q_in so the cascade rotates.
module sn74ls194_seq
  import sn74ls194_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_SHIFT = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] nbits,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] d,
  output logic             r,
  output logic             l,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic cnt_zero, cnt_one;
  logic ser_fwd;

  assign accept = (state_q == StIdle) && start;

  sn74ls194_seq_cnt #(
    .CNT_W     (CNT_W),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_cnt (
    .clk        (clk),
    .clr        (clr),
    .load_i     (accept),
    .load_val_i (nbits),
    .dec_i      (state_q == StShift),
    .is_zero_o  (cnt_zero),
    .is_one_o   (cnt_one)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    d_d     = d_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          dir_d   = dir;
          d_d     = data;
        end
      end
      StLoad:  state_d = cnt_zero ? StDone : StShift;
      StShift: if (cnt_one) state_d = StDone;
      StDone:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they are a pure function of the state register.
  always_comb begin
    mode_d = MODE_HOLD;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      StIdle:  mode_d = MODE_HOLD;
      StLoad: begin
        mode_d = MODE_LOAD;
        busy_d = 1'b1;
      end
      StShift: begin
        mode_d = shift_mode(dir_d);
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      d_q     <= '0;
      mode_q  <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SN74LS194_SEQ_ROTATE_EN
  // Recirculate the bit that falls off the far end of the cascade.
  assign ser_fwd = dir_q ? q_in[0] : q_in[WIDTH-1];
  logic unused_ser_in;
  assign unused_ser_in = ser_in;
`else
  assign ser_fwd = ser_in;
  logic unused_q_in;
  assign unused_q_in = ^q_in;
`endif

  assign r = (state_q == StShift) && !dir_q && ser_fwd;
  assign l = (state_q == StShift) &&  dir_q && ser_fwd;

  assign s1   = mode_q[1];
  assign s0   = mode_q[0];
  assign d    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sn74ls194_seq.sv
// Bench for sn74ls194_seq: per-cycle schedule model, attached 194 register model, directed vectors.
module tb_sn74ls194_seq;

  localparam int W    = 4;
  localparam int MAXS = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          clr, start, dir, ser_in;
  logic [W-1:0]  data, q_in, d;
  logic [CW-1:0] nbits;
  logic          s1, s0, r, l, busy, done;

  always #5 clk = ~clk;

  sn74ls194_seq #(
    .WIDTH     (W),
    .MAX_SHIFT (MAXS),
    .CNT_W     (CW)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .dir    (dir),
    .data   (data),
    .nbits  (nbits),
    .ser_in (ser_in),
    .q_in   (q_in),
    .s1     (s1),
    .s0     (s0),
    .d      (d),
    .r      (r),
    .l      (l),
    .busy   (busy),
    .done   (done)
  );

  // Expected per-cycle pin pattern of an accepted transaction, one entry per cycle.
  typedef struct packed {
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       shifting;
  } step_t;

  step_t        sched[$];
  logic [W-1:0] exp_d;
  logic         exp_dir;
  logic [W-1:0] q194;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           chk_en = 0;
  int           shift_cyc = 0;
  int           cyc;

  assign q_in = q194;

  // Attached 194 register, driven only by the DUT pins.
  always @(posedge clk) begin
    case ({s1, s0})
      2'b11:   q194 <= d;
      2'b01:   q194 <= {q194[W-2:0], r};
      2'b10:   q194 <= {l, q194[W-1:1]};
      default: q194 <= q194;
    endcase
  end

  // Transaction model: on acceptance, lay out LOAD, N shift cycles, DONE.
  int n_model;
  always @(posedge clk) begin
    if (clr) begin
      sched.delete();
      exp_d   <= '0;
      exp_dir <= 1'b0;
    end else if (sched.size() > 0) begin
      sched.pop_front();
    end else if (start) begin
      n_model = (int'(nbits) > MAXS) ? MAXS : int'(nbits);
      exp_d   <= data;
      exp_dir <= dir;
      sched.push_back('{2'b11, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < n_model; i++)
        sched.push_back('{(dir ? 2'b10 : 2'b01), 1'b1, 1'b0, 1'b1});
      sched.push_back('{2'b00, 1'b0, 1'b1, 1'b0});
    end
  end

  logic [1:0] em;
  logic       eb, ed, esh, sv, er, el;
  always @(negedge clk) begin
    if (chk_en) begin
      if (sched.size() == 0) begin
        em = 2'b00; eb = 1'b0; ed = 1'b0; esh = 1'b0;
      end else begin
        em = sched[0].mode; eb = sched[0].busy; ed = sched[0].done; esh = sched[0].shifting;
      end
`ifdef SN74LS194_SEQ_ROTATE_EN
      sv = exp_dir ? q194[0] : q194[W-1];
`else
      sv = ser_in;
`endif
      er = esh && !exp_dir && sv;
      el = esh &&  exp_dir && sv;
      n_cmp++;
      if ({s1, s0, busy, done, d, r, l} !== {em, eb, ed, exp_d, er, el}) begin
        n_bad++;
        $display("FAIL cycle_model @%0t: got s1s0=%b busy=%b done=%b d=%b r=%b l=%b, expected s1s0=%b busy=%b done=%b d=%b r=%b l=%b",
                 $time, {s1, s0}, busy, done, d, r, l, em, eb, ed, exp_d, er, el);
      end
      if (s1 ^ s0) shift_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Runs one transaction; returns edges from acceptance to done, ends back in IDLE.
  task automatic txn(input logic [W-1:0] dat, input logic [CW-1:0] nb, input logic dr,
                     input logic si, output int cycles);
    data = dat; nbits = nb; dir = dr; ser_in = si; start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
    chk("done_reached", done, 1);
    tick();
    chk("done_one_pulse", done, 0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; dir = 1'b0; ser_in = 1'b0; data = '0; nbits = '0;
    tick();
    tick();
    clr    = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", {s1, s0, busy, done, r, l, d}, 0);

    // Transmit 1011 toward the MSB, zeros shifted in.
    txn(4'b1011, 3'd4, 1'b0, 1'b0, cyc);
    chk("lat_n4", cyc, 6);
    chk("q_n4", q194, 4'b0000);

    txn(4'b0001, 3'd2, 1'b1, 1'b1, cyc);
    chk("lat_n2", cyc, 4);
    chk("q_shl", q194, 4'b1100);

    shift_cyc = 0;
    txn(4'b0110, 3'd0, 1'b0, 1'b1, cyc);
    chk("lat_n0", cyc, 2);
    chk("q_n0", q194, 4'b0110);
    chk("shifts_n0", shift_cyc, 0);

    // Saturating count; start pulses in SHIFT and DONE must be ignored.
    shift_cyc = 0;
    data = 4'b1010; nbits = 3'd7; dir = 1'b0; ser_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; data = 4'b0101; nbits = 3'd1; dir = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) tick();
    chk("sat_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sat_idle", {s1, s0, busy, done}, 0);
    chk("sat_shifts", shift_cyc, 4);
    chk("sat_q", q194, 4'b1111);
    chk("sat_d_kept", d, 4'b1010);

    // Reset mid-SHIFT, then a normal transaction.
    data = 4'b1100; nbits = 3'd4; dir = 1'b0; ser_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_shift_busy", {s1, s0, busy}, 3'b011);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rst_mid", {s1, s0, busy, done, r, l, d}, 0);
    txn(4'b0011, 3'd1, 1'b0, 1'b1, cyc);
    chk("lat_after_rst", cyc, 3);
    chk("q_after_rst", q194, 4'b0111);

    txn(4'b1000, 3'd1, 1'b0, 1'b0, cyc);
`ifdef SN74LS194_SEQ_ROTATE_EN
    chk("q_rotate", q194, 4'b0001);
`else
    chk("q_rotate", q194, 4'b0000);
`endif

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
